fifo_burst_reader: RTL and testbench

//  Drains a single-clock sync FIFO from its read side (empty/count/dataout in, readout pop out).

---
 rtl/fifo_burst_reader_pkg.sv | 10 +
 rtl/fifo_burst_reader_if.sv | 25 ++
 rtl/fifo_out_skid.sv | 34 +++
 rtl/fifo_burst_reader.sv | 90 +++++++++
 tb/tb_fifo_burst_reader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg: shared types and widths for the FIFO burst reader.
package fifo_burst_reader_pkg;
    localparam int DATA_W = 32;
    localparam int BURST_CNT_W = 16;
    typedef enum logic {IDLE, BURST} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic last;
    } skid_entry_t;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: FIFO read-side and output stream signals of the burst reader.
interface fifo_burst_reader_if
    import fifo_burst_reader_pkg::*;
#(
    parameter int WID = DATA_W,
    parameter int DEPTH = 8,
    parameter int AWID = $clog2(DEPTH)
);
    logic fifo_empty;
    logic [AWID:0] fifo_count;
    logic [WID-1:0] fifo_dataout;
    logic fifo_readout;
    logic out_valid;
    logic [WID-1:0] out_data;
    logic out_last;
    logic out_ready;
    modport master (
        input fifo_empty, fifo_count, fifo_dataout, out_ready,
        output fifo_readout, out_valid, out_data, out_last
    );
    modport slave (
        output fifo_empty, fifo_count, fifo_dataout, out_ready,
        input fifo_readout, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_out_skid.sv
// fifo_out_skid: 2-entry valid/ready skid buffer carrying {data,last}; e0 is the head.
module fifo_out_skid
    import fifo_burst_reader_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic push,
    input skid_entry_t din,
    output logic out_valid,
    output skid_entry_t dout,
    input logic out_ready,
    output logic [1:0] cnt
);
    skid_entry_t e0, e1;
    logic deq;
    assign deq = out_valid && out_ready;
    assign out_valid = cnt != 2'd0;
    assign dout = e0;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
            e0 <= '0;
            e1 <= '0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(deq);
            if (push && (cnt == 2'd0 || (deq && cnt == 2'd1)))
                e0 <= din;
            else if (deq && cnt == 2'd2)
                e0 <= e1;
            if (push && ((cnt == 2'd1 && !deq) || (cnt == 2'd2 && deq)))
                e1 <= din;
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a sync FIFO into last-tagged bursts on a valid/ready stream.
// Optional idle timeout for short bursts: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WID = DATA_W,
    parameter int DEPTH = 8,
    parameter int AWID = $clog2(DEPTH)
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16,
    parameter int TWID = $clog2(TIMEOUT + 1)
`endif
) (
    input logic clk,
    input logic rst,
    fifo_burst_reader_if.master bus,
    input logic [AWID:0] burst_len,
    input logic flush,
    output logic busy,
    output logic [BURST_CNT_W-1:0] burst_cnt
);
    state_t state, state_n;
    logic [AWID:0] remaining, remaining_n, bl;
    logic pop, timeout, start_short;
    logic [1:0] skid_cnt;
    skid_entry_t skid_in, skid_out;
    assign bl = burst_len == '0 ? (AWID+1)'(1) :
                burst_len > (AWID+1)'(DEPTH) ? (AWID+1)'(DEPTH) : burst_len;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    logic [TWID-1:0] timer;
    always_ff @(posedge clk) begin
        if (rst || state != IDLE || bus.fifo_empty)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end
    assign timeout = timer == TWID'(TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif
    assign start_short = (flush || timeout) && !bus.fifo_empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            remaining <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_n;
            remaining <= remaining_n;
            if (bus.out_valid && bus.out_ready && bus.out_last)
                burst_cnt <= burst_cnt + 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        remaining_n = remaining;
        if (state == IDLE) begin
            if (bus.fifo_count >= bl) begin
                state_n = BURST;
                remaining_n = bl;
            end else if (start_short) begin
                state_n = BURST;
                remaining_n = bus.fifo_count;
            end
        end else if (pop) begin
            remaining_n = remaining - 1'b1;
            state_n = remaining == (AWID+1)'(1) ? IDLE : BURST;
        end
    end
    // Pop depends only on registered state and the FIFO flag, never on out_ready.
    always_comb begin
        pop = state == BURST && remaining != '0 && !bus.fifo_empty && skid_cnt != 2'd2;
        busy = state == BURST || skid_cnt != 2'd0;
    end
    assign bus.fifo_readout = pop;
    assign skid_in = '{data: bus.fifo_dataout, last: remaining == (AWID+1)'(1)};
    assign bus.out_data = skid_out.data;
    assign bus.out_last = skid_out.last;
    fifo_out_skid u_skid (
        .clk(clk),
        .rst(rst),
        .push(pop),
        .din(skid_in),
        .out_valid(bus.out_valid),
        .dout(skid_out),
        .out_ready(bus.out_ready),
        .cnt(skid_cnt)
    );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and randomized checks of fifo_burst_reader against a word/burst-length scoreboard.
module tb_fifo_burst_reader;
    localparam int WID = 32;
    localparam int DEPTH = 8;
    localparam int AWID = 3;
    logic clk, rst, flush, busy;
    logic [AWID:0] burst_len;
    logic [15:0] burst_cnt;
    fifo_burst_reader_if #(.WID(WID), .DEPTH(DEPTH), .AWID(AWID)) bus ();
    fifo_burst_reader dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .burst_len(burst_len),
        .flush(flush),
        .busy(busy),
        .burst_cnt(burst_cnt)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int n_assert, n_fail, pos, exp_bc, occ, tot_pops;
    logic [WID-1:0] q[$], exp_q[$];
    int lens[$];
    bit stalled;
    logic [WID:0] held;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive_fifo();
        bus.fifo_count = (AWID+1)'(q.size());
        bus.fifo_empty = q.size() == 0;
        bus.fifo_dataout = q.size() != 0 ? q[0] : '0;
    endtask
    // One clock: check the stream at the negedge, then update the FIFO model after the posedge.
    task automatic tick(input bit want_push, input logic [WID-1:0] d, input bit rdy, output bit pushed);
        bit pop, acc, el;
        pop = bus.fifo_readout;
        acc = bus.out_valid && bus.out_ready;
        if (!rst) begin
            chk("burst_cnt", 64'(burst_cnt), 64'(exp_bc));
            chk("valid_latency", 64'(bus.out_valid), 64'(occ != 0));
            chk("skid_occupancy", 64'(occ <= 2), 64'(1));
            if (stalled) begin
                chk("hold_valid", 64'(bus.out_valid), 64'(1));
                chk("hold_data", 64'({bus.out_last, bus.out_data}), 64'(held));
            end
            if (pop) begin
                chk("underflow", 64'(bus.fifo_empty), 64'(0));
                tot_pops++;
            end
            if (acc && exp_q.size() == 0)
                chk("spurious_beat", 64'(bus.out_valid), 64'(0));
            else if (acc) begin
                el = lens.size() != 0 && pos + 1 == lens[0];
                chk("data", 64'(bus.out_data), 64'(exp_q[0]));
                chk("last", 64'(bus.out_last), 64'(el));
                void'(exp_q.pop_front());
                pos++;
                if (el) begin
                    void'(lens.pop_front());
                    pos = 0;
                    exp_bc++;
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = {bus.out_last, bus.out_data};
        end
        @(posedge clk);
        #1;
        pushed = want_push && (q.size() - int'(pop) < DEPTH);
        if (pop && q.size() != 0) void'(q.pop_front());
        if (pushed) begin
            q.push_back(d);
            exp_q.push_back(d);
        end
        occ = occ + int'(pop) - int'(acc);
        if (rst) begin
            exp_q = q;
            lens.delete();
            pos = 0;
            exp_bc = 0;
            stalled = 0;
            occ = 0;
        end
        bus.out_ready = rdy;
        drive_fifo();
        @(negedge clk);
    endtask
    task automatic push_n(input int n, input bit rdy);
        int k = 0, c = 0;
        bit p;
        while (k < n && c < 100) begin
            tick(1'b1, $urandom, rdy, p);
            k += int'(p);
            c++;
        end
        chk("push_budget", 64'(k), 64'(n));
    endtask
    task automatic drain(input int budget);
        int c = 0;
        bit p;
        while ((exp_q.size() != 0 || occ != 0) && c < budget) begin
            tick(1'b0, '0, $urandom_range(0, 3) != 0, p);
            c++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'(0));
    endtask
    // Random traffic at one burst length: full bursts of clamp(b), then a flushed remainder.
    task automatic phase(input int b, input int n);
        int bb, k, c;
        bit p, w;
        burst_len = (AWID+1)'(b);
        bb = b == 0 ? 1 : (b > DEPTH ? DEPTH : b);
        for (int i = 0; i < n / bb; i++) lens.push_back(bb);
        k = 0;
        c = 0;
        while (k < n && c < 400) begin
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            w = 1'b1;
`else
            w = $urandom_range(0, 1) != 0;
`endif
            tick(w, $urandom, $urandom_range(0, 3) != 0, p);
            k += int'(p);
            c++;
        end
        chk("phase_pushes", 64'(k), 64'(n));
        if (n % bb != 0) begin
            lens.push_back(n % bb);
            flush = 1'b1;
        end
        drain(300);
        flush = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        bit p;
        int c, d;
        rst = 1'b1;
        flush = 1'b0;
        burst_len = 4'd4;
        bus.out_ready = 1'b1;
        drive_fifo();
        @(negedge clk);
        tick(1'b0, '0, 1'b1, p);
        rst = 1'b0;
        chk("reset_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_burst_cnt", 64'(burst_cnt), 64'(0));
        chk("reset_readout", 64'(bus.fifo_readout), 64'(0));
        chk("reset_data", 64'(bus.out_data), 64'(0));
        chk("reset_last", 64'(bus.out_last), 64'(0));
        lens.push_back(4);
        push_n(4, 1'b1);
        chk("start_latency_idle", 64'(bus.fifo_readout), 64'(0));
        tick(1'b0, '0, 1'b1, p);
        chk("start_latency_pop", 64'(bus.fifo_readout), 64'(1));
        chk("busy_in_burst", 64'(busy), 64'(1));
        drain(50);
        chk("full_burst_cnt", 64'(burst_cnt), 64'(1));
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        lens.push_back(2);
        push_n(2, 1'b1);
        d = 1;
        while (!bus.fifo_readout && d < 40) begin
            tick(1'b0, '0, 1'b1, p);
            d++;
        end
        chk("timeout_delay", 64'(d), 64'(16));
        drain(50);
        chk("short_burst_cnt", 64'(burst_cnt), 64'(2));
`else
        push_n(3, 1'b1);
        c = tot_pops;
        repeat (100) tick(1'b0, '0, 1'b1, p);
        chk("no_partial_pop", 64'(tot_pops - c), 64'(0));
        lens.push_back(3);
        flush = 1'b1;
        drain(50);
        flush = 1'b0;
        chk("flush_burst_cnt", 64'(burst_cnt), 64'(2));
`endif
        burst_len = 4'd8;
        lens.push_back(8);
        push_n(8, 1'b0);
        repeat (5) tick(1'b0, '0, 1'b0, p);
        chk("stall_pops", 64'(DEPTH - q.size()), 64'(2));
        for (int i = 0; i < 40; i++) tick(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), p);
        drain(100);
        burst_len = 4'd4;
        lens.push_back(4);
        push_n(4, 1'b1);
        c = 0;
        while (q.size() > 2 && c < 20) begin
            tick(1'b0, '0, 1'b1, p);
            c++;
        end
        chk("reset_point", 64'(q.size()), 64'(2));
        rst = 1'b1;
        tick(1'b0, '0, 1'b1, p);
        rst = 1'b0;
        chk("midrst_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_burst_cnt", 64'(burst_cnt), 64'(0));
        chk("midrst_readout", 64'(bus.fifo_readout), 64'(0));
        if (q.size() != 0) begin
            lens.push_back(q.size());
            flush = 1'b1;
            drain(50);
            flush = 1'b0;
        end
        phase(0, 5);
        phase(15, 16);
        repeat (6) phase($urandom_range(0, 15), $urandom_range(1, 24));
        tick(1'b0, '0, 1'b1, p);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
